// File: rtl/encoder8_scan_if.sv
// encoder8_scan_if
//   Handshake bundle between a vector producer / index consumer and the
//   encoder8_scan block.
//
//   Signals:
//     ena       load strobe from the producer
//     e[7:0]    request vector, bit i set means index i is to be emitted
//     in_ready  encoder is idle and can take a new vector
//     valid     n carries an index awaiting acceptance
//     n[2:0]    lowest pending index
//     last      the index on n is the final one of the current vector
//     ready     consumer accepts n this cycle
//     none      one-cycle pulse after an all-zero vector was loaded
//
//   Modports:
//     master    the environment side (drives ena, e, ready)
//     slave     the encoder side (drives in_ready, valid, n, last, none)

interface encoder8_scan_if;
    logic       ena;
    logic [7:0] e;
    logic       in_ready;
    logic       valid;
    logic [2:0] n;
    logic       last;
    logic       ready;
    logic       none;

    modport master (
        output ena,
        output e,
        output ready,
        input  in_ready,
        input  valid,
        input  n,
        input  last,
        input  none
    );

    modport slave (
        input  ena,
        input  e,
        input  ready,
        output in_ready,
        output valid,
        output n,
        output last,
        output none
    );
endinterface

// File: rtl/encoder8_scan.sv
// encoder8_scan
//   Captures an 8-bit request vector and emits the index of every set bit,
//   lowest first, one index per accepted handshake. An all-zero vector is
//   not scanned; it produces a single-cycle 'none' pulse instead.
//
//   Ports:
//     clk    rising-edge clock for all state
//     clrn   asynchronous active-low clear of all state
//     bus    encoder8_scan_if.slave handshake bundle (ena, e, ready in;
//            in_ready, valid, n, last, none out)
//
//   Every output is decoded from registers only, so none of ena, e or ready
//   has a combinational path to an output.

module encoder8_scan (
    input  logic                 clk,
    input  logic                 clrn,
    encoder8_scan_if.slave       bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pend_q,  pend_d;
    logic       none_q,  none_d;

    logic [2:0] lowIdx;
    logic       oneLeft;

    // Priority encoder: walking from the top bit down lets the lowest set
    // bit win. An empty pend leaves the index at zero.
    always_comb begin
        lowIdx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pend_q[i]) begin
                lowIdx = 3'(i);
            end
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit empties it.
    assign oneLeft = (pend_q != 8'd0) && ((pend_q & (pend_q - 8'd1)) == 8'd0);

    // Next-state logic. ena/e are only looked at in IDLE, so a load strobe
    // held during a scan (even on the final handshake) is ignored and can
    // only be taken the cycle after the scan returns to IDLE.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        none_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.ena) begin
                    if (bus.e != 8'd0) begin
                        pend_d  = bus.e;
                        state_d = SCAN;
                    end else begin
                        none_d  = 1'b1;
                    end
                end
            end

            SCAN: begin
                if (bus.ready) begin
                    if (oneLeft) begin
                        pend_d  = 8'd0;
                        state_d = IDLE;
                    end else begin
                        pend_d  = pend_q & ~(8'd1 << lowIdx);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                pend_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            pend_q  <= 8'd0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            none_q  <= none_d;
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.valid    = (state_q == SCAN);
    assign bus.n        = lowIdx;
    assign bus.last     = (state_q == SCAN) && oneLeft;
    assign bus.none     = none_q;

endmodule

// File: tb/tb_encoder8_scan.sv
// tb_encoder8_scan
//   Self-checking bench for encoder8_scan. Loading a vector pushes the
//   expected (index, last) sequence onto a queue; each observed handshake
//   pops the front entry and compares.

module tb_encoder8_scan;

    logic clk = 1'b0;
    logic clrn;

    always #5 clk = ~clk;

    encoder8_scan_if bus ();

    encoder8_scan dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic [2:0] n;
        logic       last;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Advance to just after the next rising edge; outputs are sampled and
    // inputs changed here, well away from the active edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model of the scan order: ascending indices, last on the top bit.
    task automatic pushVector(input logic [7:0] v);
        int   hi;
        exp_t x;
        hi = -1;
        for (int i = 0; i < 8; i++) if (v[i]) hi = i;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                x.n    = 3'(i);
                x.last = (i == hi);
                expQ.push_back(x);
            end
        end
    endtask

    task automatic test_reset;
        clrn      = 1'b0;
        bus.ena   = 1'b0;
        bus.e     = 8'd0;
        bus.ready = 1'b0;
        #2;
        checks++;
        if ({bus.valid, bus.n, bus.last, bus.in_ready, bus.none} !== {1'b0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got v=%b n=%0d l=%b ir=%b none=%b, want v=0 n=0 l=0 ir=1 none=0",
                     bus.valid, bus.n, bus.last, bus.in_ready, bus.none);
        end
        @(negedge clk);
        clrn = 1'b1;
        tick();
    endtask

    // Load A4 with ready held high: three back-to-back indices 2,5,7.
    task automatic test_basic;
        exp_t x;
        bus.e = 8'hA4; bus.ena = 1'b1; bus.ready = 1'b1;
        pushVector(8'hA4);
        tick();
        bus.ena = 1'b0; bus.e = 8'd0;
        for (int c = 0; c < 20 && expQ.size() > 0; c++) begin
            checks++;
            if (bus.valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL basic_valid: got valid=%b in_ready=%b, want valid=1 in_ready=0", bus.valid, bus.in_ready);
            end else begin
                x = expQ.pop_front();
                checks++;
                if ({bus.n, bus.last} !== {x.n, x.last}) begin
                    errors++;
                    $display("[TB] FAIL basic_index: got n=%0d last=%b, want n=%0d last=%b", bus.n, bus.last, x.n, x.last);
                end
            end
            tick();
        end
        checks++;
        if (expQ.size() != 0 || bus.valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_done: got pending=%0d valid=%b in_ready=%b, want pending=0 valid=0 in_ready=1",
                     expQ.size(), bus.valid, bus.in_ready);
        end
        expQ.delete();
    endtask

    // FF with ready toggling 1,0,1,1,0,1,...; outputs must hold on stalls.
    task automatic test_ready_pattern;
        exp_t       x;
        logic [2:0] sN;
        logic       sV, sL, stalled;
        int         hs;
        hs = 0;
        bus.e = 8'hFF; bus.ena = 1'b1; bus.ready = 1'b0;
        pushVector(8'hFF);
        tick();
        bus.ena = 1'b0; bus.e = 8'd0;
        for (int c = 0; c < 40 && expQ.size() > 0; c++) begin
            bus.ready = (c % 3 != 1);
            stalled = !bus.ready;
            sN = bus.n; sV = bus.valid; sL = bus.last;
            if (bus.ready) begin
                checks++;
                if (bus.valid !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL pattern_valid: got valid=%b, want 1", bus.valid);
                end else begin
                    x = expQ.pop_front();
                    hs++;
                    checks++;
                    if ({bus.n, bus.last} !== {x.n, x.last}) begin
                        errors++;
                        $display("[TB] FAIL pattern_index: got n=%0d last=%b, want n=%0d last=%b", bus.n, bus.last, x.n, x.last);
                    end
                end
            end
            tick();
            if (stalled) begin
                checks++;
                if ({bus.n, bus.valid, bus.last} !== {sN, sV, sL} || sV !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL pattern_hold: got n=%0d v=%b l=%b, want n=%0d v=1 l=%b", bus.n, bus.valid, bus.last, sN, sL);
                end
            end
        end
        checks++;
        if (hs != 8 || bus.valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pattern_count: got handshakes=%0d valid=%b, want handshakes=8 valid=0", hs, bus.valid);
        end
        bus.ready = 1'b0;
        expQ.delete();
    endtask

    // All-zero load pulses none for one cycle, then a single-bit vector.
    task automatic test_none;
        exp_t x;
        bus.e = 8'h00; bus.ena = 1'b1; bus.ready = 1'b0;
        tick();
        bus.ena = 1'b0;
        checks++;
        if ({bus.none, bus.valid, bus.in_ready} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL none_pulse: got none=%b valid=%b in_ready=%b, want none=1 valid=0 in_ready=1",
                     bus.none, bus.valid, bus.in_ready);
        end
        tick();
        checks++;
        if ({bus.none, bus.valid, bus.in_ready} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL none_clear: got none=%b valid=%b in_ready=%b, want none=0 valid=0 in_ready=1",
                     bus.none, bus.valid, bus.in_ready);
        end
        bus.e = 8'h80; bus.ena = 1'b1; bus.ready = 1'b1;
        pushVector(8'h80);
        tick();
        bus.ena = 1'b0; bus.e = 8'd0;
        for (int c = 0; c < 10 && expQ.size() > 0; c++) begin
            checks++;
            if (bus.valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL single_valid: got valid=%b, want 1", bus.valid);
            end else begin
                x = expQ.pop_front();
                checks++;
                if ({bus.n, bus.last, bus.none} !== {x.n, x.last, 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL single_index: got n=%0d last=%b none=%b, want n=%0d last=%b none=0",
                             bus.n, bus.last, bus.none, x.n, x.last);
                end
            end
            tick();
        end
        checks++;
        if (expQ.size() != 0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_done: got pending=%0d in_ready=%b, want pending=0 in_ready=1", expQ.size(), bus.in_ready);
        end
        expQ.delete();
    endtask

    // Back-to-back: ena/e held during the scan of 03 must be ignored until
    // the cycle after the final handshake, then 40 loads and gives n=6.
    task automatic test_back_to_back;
        exp_t x;
        bus.e = 8'h03; bus.ena = 1'b1; bus.ready = 1'b1;
        pushVector(8'h03);
        tick();
        bus.e = 8'h40;
        for (int c = 0; c < 10 && expQ.size() > 0; c++) begin
            checks++;
            if (bus.valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_valid: got valid=%b, want 1", bus.valid);
            end else begin
                x = expQ.pop_front();
                checks++;
                if ({bus.n, bus.last} !== {x.n, x.last}) begin
                    errors++;
                    $display("[TB] FAIL b2b_index: got n=%0d last=%b, want n=%0d last=%b", bus.n, bus.last, x.n, x.last);
                end
            end
            tick();
        end
        checks++;
        if (expQ.size() != 0 || bus.valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_gap: got pending=%0d valid=%b in_ready=%b, want pending=0 valid=0 in_ready=1",
                     expQ.size(), bus.valid, bus.in_ready);
        end
        pushVector(8'h40);
        tick();
        bus.ena = 1'b0; bus.e = 8'd0;
        for (int c = 0; c < 10 && expQ.size() > 0; c++) begin
            checks++;
            if (bus.valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_second_valid: got valid=%b, want 1", bus.valid);
            end else begin
                x = expQ.pop_front();
                checks++;
                if ({bus.n, bus.last} !== {x.n, x.last}) begin
                    errors++;
                    $display("[TB] FAIL b2b_second_index: got n=%0d last=%b, want n=%0d last=%b", bus.n, bus.last, x.n, x.last);
                end
            end
            tick();
        end
        checks++;
        if (expQ.size() != 0 || bus.valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_done: got pending=%0d valid=%b, want pending=0 valid=0", expQ.size(), bus.valid);
        end
        expQ.delete();
    endtask

    // Asynchronous clear mid-scan discards index 7; the first edge after
    // release loads 10 and only n=4 may follow.
    task automatic test_async_reset;
        exp_t x;
        bus.e = 8'h81; bus.ena = 1'b1; bus.ready = 1'b1;
        pushVector(8'h81);
        tick();
        bus.ena = 1'b0; bus.e = 8'd0;
        x = expQ.pop_front();
        checks++;
        if ({bus.valid, bus.n, bus.last} !== {1'b1, x.n, x.last}) begin
            errors++;
            $display("[TB] FAIL areset_first: got v=%b n=%0d l=%b, want v=1 n=%0d l=%b", bus.valid, bus.n, bus.last, x.n, x.last);
        end
        tick();
        bus.ready = 1'b0;
        #2;
        clrn = 1'b0;
        #1;
        checks++;
        if ({bus.valid, bus.n, bus.last, bus.in_ready} !== {1'b0, 3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL areset_immediate: got v=%b n=%0d l=%b ir=%b, want v=0 n=0 l=0 ir=1",
                     bus.valid, bus.n, bus.last, bus.in_ready);
        end
        expQ.delete();
        bus.ready = 1'b1;
        tick();
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL areset_hold: got valid=%b, want 0", bus.valid);
        end
        @(negedge clk);
        clrn = 1'b1;
        bus.e = 8'h10; bus.ena = 1'b1;
        pushVector(8'h10);
        tick();
        bus.ena = 1'b0; bus.e = 8'd0;
        for (int c = 0; c < 10 && expQ.size() > 0; c++) begin
            checks++;
            if (bus.valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL areset_reload_valid: got valid=%b, want 1", bus.valid);
            end else begin
                x = expQ.pop_front();
                checks++;
                if ({bus.n, bus.last} !== {x.n, x.last}) begin
                    errors++;
                    $display("[TB] FAIL areset_reload_index: got n=%0d last=%b, want n=%0d last=%b", bus.n, bus.last, x.n, x.last);
                end
            end
            tick();
        end
        checks++;
        if (expQ.size() != 0 || bus.valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL areset_done: got pending=%0d valid=%b, want pending=0 valid=0", expQ.size(), bus.valid);
        end
        expQ.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ready_pattern();
        test_none();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

endmodule
